// File: rtl/mem_bus_arbiter_pkg.sv
// mem_bus_arbiter_pkg: shared word/line widths and arbiter state encoding
package mem_bus_arbiter_pkg;
  localparam int WORD_SIZE = 16;
  localparam int LINE_W = 4 * WORD_SIZE;
  typedef enum logic [1:0] {
    CPU_OWN = 2'd0,
    DRAIN   = 2'd1,
    DMA_OWN = 2'd2
  } state_t;
endpackage

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: CPU/DMA memory port arbiter with BR/BG handshake, drain and CPU cool-down window
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W = WORD_SIZE,
  parameter int DATA_W = LINE_W,
  parameter int MIN_CPU_WINDOW = 4
) (
  input  logic              CLK,
  input  logic              reset_n,
  input  logic              cpu_read,
  input  logic              cpu_write,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_stall,
  input  logic              BR,
  output logic              BG,
  input  logic              dma_write,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  input  logic              mem_busy,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              protocol_err
);
  state_t state, next;
  logic [3:0] cool_cnt;
  logic cpu_own, dma_own;
  assign cpu_own = state == CPU_OWN;
  assign dma_own = state == DMA_OWN;
  // Next-state: grant only after the cool-down expires and the bus is quiet
  always_comb begin
    next = state;
    case (state)
      CPU_OWN: if (BR && cool_cnt == 4'd0) next = (!mem_busy && !cpu_read && !cpu_write) ? DMA_OWN : DRAIN;
      DRAIN:   next = !BR ? CPU_OWN : (!mem_busy ? DMA_OWN : DRAIN);
      DMA_OWN: next = BR ? DMA_OWN : CPU_OWN;
      default: next = CPU_OWN;
    endcase
  end
  // State plus BG/cpu_stall as dedicated flops so they never glitch on state transitions
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state <= CPU_OWN;
      BG <= 1'b0;
      cpu_stall <= 1'b0;
    end else begin
      state <= next;
      BG <= next == DMA_OWN;
      cpu_stall <= next != CPU_OWN;
    end
  end
  // Cool-down: reload on DMA release, count down to zero while the CPU owns the bus
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) cool_cnt <= 4'd0;
    else if (dma_own && next == CPU_OWN) cool_cnt <= 4'(MIN_CPU_WINDOW);
    else if (cpu_own && cool_cnt != 4'd0) cool_cnt <= cool_cnt - 4'd1;
  end
  // Sticky flag for DMA writes issued without a grant
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) protocol_err <= 1'b0;
    else if (dma_write && !dma_own) protocol_err <= 1'b1;
  end
  assign mem_read  = cpu_own && cpu_read;
  assign mem_write = cpu_own ? cpu_write : (dma_own && dma_write);
  assign mem_addr  = dma_own ? dma_addr : cpu_addr;
  assign mem_wdata = dma_own ? dma_wdata : cpu_wdata;
endmodule
